fmap_window_reader: RTL and testbench

- Read-side controller placed directly downstream of the feature-map simple dual-port RAM.
- Drives the RAM read port (enable, address) and gathers the pixels of each KxK stride-1 "valid" convolution window into one flattened vector.
- Hands each window to the MAC/PE array over a valid/ready handshake.
- One run is triggered by `start` and covers one feature map stored in raster order from `base_addr`.

---
 rtl/fmap_window_reader.sv | 136 +++++++++++++
 tb/tb_fmap_window_reader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_window_reader.sv
// Feature-map read controller: fetches each KxK stride-1 window from the
// RAM read port and presents it flattened over a valid/ready handshake.
module fmap_window_reader #(
  parameter int WIDTH     = 4,
  parameter int ADDRWIDTH = 8,
  parameter int IMG_W     = 16,
  parameter int IMG_H     = 16,
  parameter int K         = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDRWIDTH-1:0]   base_addr,
  output logic                   ram_enb,
  output logic [ADDRWIDTH-1:0]   ram_addrb,
  input  logic [WIDTH-1:0]       ram_dob,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [K*K*WIDTH-1:0]   out_window,
  output logic [7:0]             out_row,
  output logic [7:0]             out_col,
  output logic                   busy,
  output logic                   done
);

  localparam int KK = K * K;
  localparam int FW = $clog2(KK + 1);
  localparam int KW = $clog2(K + 1);

  if (IMG_W * IMG_H > (longint'(1) << ADDRWIDTH)) begin : g_size_chk
    $error("feature map does not fit in the RAM address space");
  end

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

  state_t                 state;
  state_t                 state_n;
  logic [FW-1:0]          f;
  logic [FW-1:0]          f_prev;
  logic [KW-1:0]          fi;
  logic [KW-1:0]          fj;
  logic [7:0]             row;
  logic [7:0]             col;
  logic [ADDRWIDTH-1:0]   base;
  logic [31:0]            offset;
  logic                   reading;
  logic                   last_win;

  assign f_prev   = f - 1'b1;
  assign reading  = (f != FW'(KK));
  assign last_win = (row == 8'(IMG_H - K)) && (col == 8'(IMG_W - K));
  assign offset   = (32'(row) + 32'(fi)) * 32'(IMG_W)
                  + 32'(col) + 32'(fj);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = FETCH;
      FETCH: if (!reading) state_n = HOLD;
      HOLD:  if (out_ready) state_n = last_win ? DONE : FETCH;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ram_enb   = (state == FETCH) && reading;
    ram_addrb = '0;
    if (ram_enb) ram_addrb = base + offset[ADDRWIDTH-1:0];
    out_valid = (state == HOLD);
    busy      = (state == FETCH) || (state == HOLD);
    done      = (state == DONE);
  end

  // Element f-1 is captured while read f is issued; the extra cycle
  // at f == K*K only captures the final element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base       <= '0;
      row        <= '0;
      col        <= '0;
      f          <= '0;
      fi         <= '0;
      fj         <= '0;
      out_window <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base <= base_addr;
            row  <= '0;
            col  <= '0;
            f    <= '0;
            fi   <= '0;
            fj   <= '0;
          end
        end
        FETCH: begin
          if (f != '0) out_window[f_prev*WIDTH +: WIDTH] <= ram_dob;
          if (reading) begin
            f <= f + 1'b1;
            if (fj == KW'(K - 1)) begin
              fj <= '0;
              fi <= fi + 1'b1;
            end else begin
              fj <= fj + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            f  <= '0;
            fi <= '0;
            fj <= '0;
            if (col == 8'(IMG_W - K)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_row = row;
  assign out_col = col;

endmodule

// File: tb/tb_fmap_window_reader.sv
// Directed and randomized bench for fmap_window_reader against a
// window-arithmetic reference model and a behavioural RAM.
module tb_fmap_window_reader;

  localparam int WIDTH = 8;
  localparam int AW    = 8;
  localparam int IW    = 4;
  localparam int IH    = 4;
  localparam int K     = 3;
  localparam int KK    = K * K;
  localparam int NC    = IW - K + 1;
  localparam int NW    = (IH - K + 1) * NC;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [AW-1:0]         base_addr;
  logic                  ram_enb;
  logic [AW-1:0]         ram_addrb;
  logic [WIDTH-1:0]      ram_dob;
  logic                  out_valid;
  logic                  out_ready;
  logic [KK*WIDTH-1:0]   out_window;
  logic [7:0]            out_row;
  logic [7:0]            out_col;
  logic                  busy;
  logic                  done;

  logic [WIDTH-1:0]      mem [256];
  int                    n_chk = 0;
  int                    n_fail = 0;
  int                    enb_cnt;
  int                    done_cnt;
  int                    run_len;
  int                    runs[$];
  logic [AW-1:0]         addrs[$];

  fmap_window_reader #(
    .WIDTH(WIDTH), .ADDRWIDTH(AW), .IMG_W(IW), .IMG_H(IH), .K(K)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_window(out_window), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_enb) ram_dob <= mem[ram_addrb];

  always @(posedge clk) begin
    if (ram_enb) begin
      enb_cnt++;
      run_len++;
      addrs.push_back(ram_addrb);
    end else if (run_len != 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input int b, input int r,
                                             input int c, input int e);
    return AW'((b + (r + e / K) * IW + c + e % K) % 256);
  endfunction

  function automatic logic [KK*WIDTH-1:0] exp_win(input int b,
                                                  input int r,
                                                  input int c);
    logic [KK*WIDTH-1:0] w;
    w = '0;
    for (int e = 0; e < KK; e++)
      w[e*WIDTH +: WIDTH] = mem[exp_addr(b, r, c, e)];
    return w;
  endfunction

  task automatic clear_mon();
    enb_cnt  = 0;
    done_cnt = 0;
    run_len  = 0;
    addrs.delete();
    runs.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_enb"},    ram_enb,    0);
    chk({tag, "_addr"},   ram_addrb,  0);
    chk({tag, "_valid"},  out_valid,  0);
    chk({tag, "_window"}, out_window, 0);
    chk({tag, "_row"},    out_row,    0);
    chk({tag, "_col"},    out_col,    0);
    chk({tag, "_busy"},   busy,       0);
    chk({tag, "_done"},   done,       0);
  endtask

  task automatic pulse_start(input logic [AW-1:0] b);
    @(negedge clk);
    base_addr = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = AW'($urandom);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // mode 0: ready held high; 1: random ready; 2: 20-cycle stall on
  // window 0; 3: start pulsed while busy; 4: reset during window 2 fetch
  task automatic run(input int b, input int mode);
    int n;
    int guard;
    bit acc;
    logic [KK*WIDTH-1:0] hw;
    out_ready = (mode == 0);
    pulse_start(AW'(b));
    wait_valid(n);
    if (mode == 0) chk("first_valid_latency", n, 10);
    for (int w = 0; w < NW; w++) begin
      if (w > 0) wait_valid(n);
      chk("valid_timeout", n < 40, 1);
      chk("row", out_row, w / NC);
      chk("col", out_col, w % NC);
      chk("window", out_window, exp_win(b, w / NC, w % NC));
      hw = out_window;
      if (mode == 2 && w == 0) begin
        out_ready = 1'b0;
        repeat (20) begin
          @(posedge clk);
          #1;
          chk("stall_valid", out_valid, 1);
          chk("stall_window", out_window, hw);
          chk("stall_rowcol", {out_row, out_col}, 16'h0000);
          chk("stall_enb", ram_enb, 0);
        end
      end
      if (mode == 3 && w == 1) begin
        out_ready = 1'b0;
        base_addr = AW'(b + 77);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_start_valid", out_valid, 1);
        chk("busy_start_window", out_window, hw);
      end
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 50) begin
        out_ready = (mode == 0 || mode == 4 || guard >= 8) ?
                    1'b1 : 1'($urandom % 2);
        @(posedge clk);
        acc = out_ready;
        #1;
        guard++;
        if (!acc) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_window", out_window, hw);
        end
      end
      chk("handshake_timeout", acc, 1);
      chk("valid_fall", out_valid, 0);
      if (mode != 0) out_ready = 1'($urandom % 2);
      if (mode == 4 && w == 1) begin
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_zero("abort");
        repeat (3) @(posedge clk);
        #1;
        chk_zero("abort_held");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (w == NW - 1) begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
      end else begin
        chk("busy_mid", busy, 1);
      end
    end
    @(posedge clk);
    #1;
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int b;
    logic [AW-1:0] wrap_list[KK];
    logic [AW-1:0] w01_list[KK];
    wrap_list = '{250, 251, 252, 254, 255, 0, 2, 3, 4};
    w01_list  = '{1, 2, 3, 5, 6, 7, 9, 10, 11};

    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    base_addr = '0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int a = 0; a < 256; a++) mem[a] = WIDTH'(a);
    clear_mon();
    run(0, 0);
    chk("basic_enb_total", enb_cnt, 36);
    chk("basic_run_count", runs.size(), 4);
    foreach (runs[i]) chk("basic_run_len", runs[i], 9);
    for (int e = 0; e < KK; e++) begin
      chk("addr_w01_model", addrs[9 + e], exp_addr(0, 0, 1, e));
      chk("addr_w01_list", addrs[9 + e], w01_list[e]);
    end
    chk("basic_done_cnt", done_cnt, 1);

    for (int a = 0; a < 256; a++) mem[a] = WIDTH'($urandom);
    clear_mon();
    run(250, 1);
    for (int e = 0; e < KK; e++)
      chk("wrap_addr", addrs[e], wrap_list[e]);
    chk("wrap_enb_total", enb_cnt, 36);

    for (int a = 0; a < 256; a++) mem[a] = WIDTH'($urandom);
    b = int'($urandom % 256);
    clear_mon();
    run(b, 2);
    chk("stall_enb_total", enb_cnt, 36);
    chk("stall_done_cnt", done_cnt, 1);

    b = int'($urandom % 256);
    clear_mon();
    run(b, 3);
    repeat (15) @(posedge clk);
    #1;
    chk("busy_start_enb_total", enb_cnt, 36);
    chk("busy_start_done_cnt", done_cnt, 1);
    chk("busy_start_idle", {out_valid, busy}, 2'b00);

    for (int a = 0; a < 256; a++) mem[a] = WIDTH'(a);
    clear_mon();
    run(0, 4);
    chk("abort_no_done", done_cnt, 0);
    clear_mon();
    run(0, 0);
    chk("rerun_enb_total", enb_cnt, 36);
    chk("rerun_done_cnt", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
